// File: rtl/conv_writeback.sv
// Convolution writeback: quantises/activates accumulated results, buffers them
// in a small FIFO and streams them to output memory at consecutive addresses.
module conv_writeback #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        output_memory_offset,
  input  logic [15:0]        output_count,
  input  logic [3:0]         shift,
  input  logic               in_valid,
  input  logic signed [17:0] in_data,
  output logic               in_ready,
  output logic               mem_we,
  output logic [15:0]        mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic               mem_ready,
  output logic               busy,
  output logic               done
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]   r_offset;
  logic [15:0]   r_count;
  logic [3:0]    r_shift;
  logic [15:0]   r_acc_cnt;
  logic [15:0]   r_wr_cnt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_fill;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_start_ok;
  logic signed [17:0] w_shifted;
  logic [7:0]         w_act;

  assign w_full     = (r_fill == CW'(FIFO_DEPTH));
  assign w_empty    = (r_fill == '0);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = mem_we & mem_ready;
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));

  // Activation: clamp negatives to zero, shift, saturate to one byte
  always_comb begin
    w_shifted = in_data >>> r_shift;
    if (in_data[17])
      w_act = 8'h00;
    else if (|w_shifted[17:8])
      w_act = 8'hFF;
    else
      w_act = w_shifted[7:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic; transitions look at this cycle's push/pop so done
  // follows the final write by exactly one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start)
          w_next = (output_count == 16'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if ((r_acc_cnt + 16'(w_push)) == r_count)
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (((r_wr_cnt + 16'(w_pop)) == r_count) &&
            ((r_fill - CW'(w_pop)) == '0))
          w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from registered state, counters and FIFO
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = r_offset + r_wr_cnt;
    mem_wdata = r_mem[r_rd_ptr];
    case (r_state)
      S_RUN: begin
        busy     = 1'b1;
        in_ready = !w_full && (r_acc_cnt < r_count);
        mem_we   = !w_empty;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        mem_we = !w_empty;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Job parameters, counters and result FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_offset  <= '0;
      r_count   <= '0;
      r_shift   <= '0;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_fill    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++)
        r_mem[i] <= '0;
    end else if (w_start_ok) begin
      r_offset  <= output_memory_offset;
      r_count   <= output_count;
      r_shift   <= shift;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_fill    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_act;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
        r_acc_cnt       <= r_acc_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
      r_fill <= r_fill + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_conv_writeback.sv
// Bench for conv_writeback: directed jobs, expected writes queued at stimulus
// time and checked by an independent write monitor.
module tb_conv_writeback;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] output_memory_offset;
  logic [15:0] output_count;
  logic [3:0]  shift;
  logic        in_valid;
  logic [17:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  last_wr_cyc = -1;
  int  ready_seen = 0;
  int  we_seen = 0;

  conv_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .output_memory_offset (output_memory_offset),
    .output_count         (output_count),
    .shift                (shift),
    .in_valid             (in_valid),
    .in_data              (in_data),
    .in_ready             (in_ready),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_ready            (mem_ready),
    .busy                 (busy),
    .done                 (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every completed write must match the head of the queue
  always @(negedge clk) begin
    if (in_ready) ready_seen++;
    if (mem_we)   we_seen++;
    if (mem_we && mem_ready) begin
      checks++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%0d, required no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%h data=%0d, required addr=%h data=%0d",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1
  task automatic start_job(input logic [15:0] off, input logic [15:0] cnt, input logic [3:0] sh);
    output_memory_offset = off;
    output_count         = cnt;
    shift                = sh;
    start                = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [17:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0, required 1 within 100 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for done, then checks it rose exactly one cycle after the last write
  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_done_latency"}, 32'(cyc - last_wr_cyc), 32'd1);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [17:0] bp_vals [6];
    int idx;
    int acc;
    logic tr;

    rst = 1'b0;
    start = 1'b1;
    output_memory_offset = 16'd1234;
    output_count = 16'd4;
    shift = 4'd1;
    in_valid = 1'b1;
    in_data = 18'd77;
    mem_ready = 1'b1;

    // Reset held during traffic: all outputs low
    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs", {in_ready, mem_we, mem_addr, mem_wdata, busy, done}, 32'd0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd0);
    chk("post_reset_busy_done", {busy, done}, 32'd0);
    @(posedge clk); #1;

    // Basic job
    expect_wr(16'd2000, 8'd25);
    expect_wr(16'd2001, 8'd0);
    expect_wr(16'd2002, 8'd255);
    expect_wr(16'd2003, 8'd255);
    start_job(16'd2000, 16'd4, 4'd2);
    send(18'd100);
    send(-18'sd5);
    send(18'd2000);
    send(18'd1023);
    wait_done("basic");

    // Backpressure with in_valid held high
    bp_vals = '{18'd10, 18'd20, 18'd30, 18'd40, 18'd50, 18'd60};
    for (int i = 0; i < 6; i++) expect_wr(16'(100 + i), 8'(10 * (i + 1)));
    mem_ready = 1'b0;
    start_job(16'd100, 16'd6, 4'd0);
    idx = 0;
    acc = 0;
    in_valid = 1'b1;
    in_data = bp_vals[0];
    repeat (12) begin
      @(negedge clk);
      tr = in_ready;
      @(posedge clk); #1;
      if (tr) begin
        acc++;
        idx++;
        if (idx < 6) in_data = bp_vals[idx];
      end
    end
    chk("bp_accepted", 32'(acc), 32'(DEPTH));
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_mem_we_held", 32'(mem_we), 32'd1);
    chk("bp_addr_stable", 32'(mem_addr), 32'd100);
    chk("bp_wdata_stable", 32'(mem_wdata), 32'd10);
    mem_ready = 1'b1;
    for (int n = 0; n < 100 && idx < 6; n++) begin
      @(negedge clk);
      tr = in_ready;
      @(posedge clk); #1;
      if (tr) begin
        idx++;
        if (idx < 6) in_data = bp_vals[idx];
      end
    end
    in_valid = 1'b0;
    chk("bp_all_sent", 32'(idx), 32'd6);
    wait_done("bp");

    // Empty job
    ready_seen = 0;
    we_seen = 0;
    output_memory_offset = 16'd500;
    output_count = 16'd0;
    shift = 4'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("empty_done", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk("empty_no_we", 32'(we_seen), 32'd0);
    chk("empty_no_ready", 32'(ready_seen), 32'd0);
    @(posedge clk); #1;

    // Address wrap
    expect_wr(16'hFFFE, 8'd1);
    expect_wr(16'hFFFF, 8'd2);
    expect_wr(16'h0000, 8'd3);
    start_job(16'hFFFE, 16'd3, 4'd0);
    send(18'd1);
    send(18'd2);
    send(18'd3);
    wait_done("wrap");

    // Reset after two of five writes
    mem_ready = 1'b0;
    expect_wr(16'd300, 8'd1);
    expect_wr(16'd301, 8'd2);
    start_job(16'd300, 16'd5, 4'd1);
    send(18'd2);
    send(18'd4);
    send(18'd6);
    send(18'd8);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("midrst_outputs", {in_ready, mem_we, mem_addr, mem_wdata, busy, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_two_writes", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("midrst_idle", {busy, done}, 32'd0);
    expect_wr(16'd50, 8'd100);
    start_job(16'd50, 16'd1, 4'd3);
    send(18'd800);
    wait_done("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_writeback.md
CONV_WRITEBACK -- requirements
Module: conv_writeback

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: result FIFO entries, power of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; latches job parameters, begins job.
REQ-005 output_memory_offset  input  16  base write address, sampled on start.
REQ-006 output_count  input  16  results expected this job, sampled on start.
REQ-007 shift  input  4  arithmetic right-shift amount for quantisation, sampled on start.
REQ-008 in_valid  input  1  accumulated convolution result valid (from Accel).
REQ-009 in_data  input  18  signed accumulated sum, bias already included.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 mem_we  output  1  output-memory write request.
REQ-012 mem_addr  output  16  write address.
REQ-013 mem_wdata  output  8  unsigned activated result.
REQ-014 mem_ready  input  1  memory accepts the write this cycle.
REQ-015 busy  output  1  high in RUN and DRAIN.
REQ-016 done  output  1  level, high in DONE until next start.

Function
REQ-017 States IDLE, RUN, DRAIN, DONE; reset enters IDLE.
REQ-018 IDLE/DONE + start: latch parameters, clear accept and write counters, go RUN; if output_count == 0 go DONE next cycle with no writes.
REQ-019 start while in RUN or DRAIN is ignored.
REQ-020 in_ready = state RUN and FIFO not full and accepted < output_count; in_ready is low on the cycle a push makes the FIFO full, independent of a simultaneous pop.
REQ-021 Input transfer on in_valid & in_ready; in_data is ignored otherwise.
REQ-022 Activation at push: negative -> 0; otherwise v = in_data >> shift; v > 255 -> 255; else v[7:0].
REQ-023 Activated byte is registered into the FIFO at push; mem_we is asserted no earlier than the cycle after the push (latency 1 with an empty FIFO and mem_ready high).
REQ-024 mem_we = FIFO not empty and state in {RUN, DRAIN}; mem_wdata = FIFO head; mem_addr = offset + write counter, modulo 2^16.
REQ-025 Write completes on mem_we & mem_ready: pop the FIFO, increment the write counter; mem_addr and mem_wdata are held stable while mem_we & !mem_ready.
REQ-026 FIFO order is strict arrival order; no entry is dropped or duplicated.
REQ-027 RUN -> DRAIN when accepted == output_count.
REQ-028 DRAIN -> DONE on the cycle after the final write completes (write counter == output_count and FIFO empty).
REQ-029 Accept and write counters are 16 bits; no result beyond output_count is ever accepted.

Reset
REQ-030 rst low asynchronously forces IDLE, empties the FIFO, and clears counters and latched parameters.
REQ-031 While rst is low: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
REQ-032 Reset mid-job abandons the job; no mem_we is issued after reset asserts; the next job requires a new start.

Verification
REQ-033 Reset: hold rst low during traffic -> all outputs 0 per REQ-031; release -> IDLE, in_ready=0.
REQ-034 Basic job: offset=2000, count=4, shift=2, mem_ready=1, inputs 100, -5, 2000, 1023 -> writes (2000,25), (2001,0), (2002,255), (2003,255); done rises one cycle after the last write.
REQ-035 Backpressure: count=6, mem_ready=0 for 12 cycles, in_valid held high -> exactly FIFO_DEPTH accepted, then in_ready=0 and mem_addr/mem_wdata stable; after release, all 6 writes occur in order.
REQ-036 Empty job: count=0 -> done=1 one cycle after start, no mem_we, in_ready never high.
REQ-037 Wrap: offset=0xFFFE, count=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-038 Reset mid-run after 2 of 5 writes -> mem_we=0 from the reset edge; a new start with count=1 completes normally.
